sha_auth_loader: RTL

- Upstream sequencer for the PMU SHA-256 user-authentication wrapper.
- Accepts a 16-word stream from the PMU config port: 8 key/block words, then 8 expected-digest words. It writes them into the wrapper's block and digest registers, fires the hash, and waits the fixed core latency.
- Samples the wrapper's match flag, scrubs the key words, and reports pass or fail.
- Counts failed attempts and locks out after MAX_ATTEMPTS.

---
 rtl/sha_auth_loader.sv | 89 ++++++++
 1 files changed

// File: rtl/sha_auth_loader.sv
// sha_auth_loader: streams key/digest words into the SHA-256 auth wrapper, fires it,
// samples the match flag after a fixed latency, scrubs the key and reports with lockout.
module sha_auth_loader #(
   parameter int MAX_ATTEMPTS = 3,
   parameter int WAIT_CYCLES  = 80,
   parameter int CNT_W        = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        sha_cs,
   output logic        sha_we,
   output logic        sha_wc,
   output logic [2:0]  sha_addr,
   output logic [31:0] sha_wdata,
   input  logic        sha_digest_valid,
   output logic        busy,
   output logic        auth_done,
   output logic        auth_pass,
   output logic        locked,
   output logic [1:0]  fail_count
);
   typedef enum logic [2:0] {IDLE, LOAD_BLK, LOAD_DIG, FIRE, WAIT, SCRUB, REPORT, LOCK} state_t;
   state_t           r_state, w_next;
   logic [2:0]       r_idx;
   logic [CNT_W-1:0] r_wait;
   logic             r_result;
   logic             w_hs, w_wr;
   logic [1:0]       w_fail_inc;
   assign w_hs       = s_valid & s_ready;
   assign w_wr       = w_hs | (r_state == SCRUB);
   assign w_fail_inc = fail_count + 2'd1;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   // FIRE spends two cycles so the last digest write has landed before sha_cs
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (start) w_next = LOAD_BLK;
         LOAD_BLK: if (w_hs && r_idx == 3'd7) w_next = LOAD_DIG;
         LOAD_DIG: if (w_hs && r_idx == 3'd7) w_next = FIRE;
         FIRE:     if (r_idx[0]) w_next = WAIT;
         WAIT:     if (r_wait == '0) w_next = SCRUB;
         SCRUB:    if (r_idx == 3'd7) w_next = REPORT;
         REPORT:   w_next = (!r_result && w_fail_inc == 2'(MAX_ATTEMPTS)) ? LOCK : IDLE;
         default:  ;
      endcase
   end
   always_comb begin
      s_ready = (r_state == LOAD_BLK) || (r_state == LOAD_DIG);
      busy    = (r_state != IDLE) && (r_state != LOCK);
      locked  = (r_state == LOCK);
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         sha_cs     <= 1'b0;
         sha_we     <= 1'b0;
         sha_wc     <= 1'b0;
         sha_addr   <= '0;
         sha_wdata  <= '0;
         r_idx      <= '0;
         r_wait     <= '0;
         r_result   <= 1'b0;
         auth_done  <= 1'b0;
         auth_pass  <= 1'b0;
         fail_count <= '0;
      end else begin
         sha_we <= w_wr;
         if (w_wr) begin
            sha_wc    <= r_state != LOAD_DIG;
            sha_addr  <= r_idx;
            sha_wdata <= (r_state == SCRUB) ? '0 : s_data;
         end
         sha_cs <= (r_state == FIRE) && r_idx[0];
         r_idx  <= (r_state == IDLE || r_state == WAIT) ? '0 :
                   (w_hs || r_state == FIRE || r_state == SCRUB) ? r_idx + 3'd1 : r_idx;
         r_wait <= (r_state == FIRE) ? CNT_W'(WAIT_CYCLES - 1) :
                   (r_state == WAIT) ? r_wait - CNT_W'(1) : r_wait;
         if (r_state == WAIT && r_wait == '0) r_result <= sha_digest_valid;
         auth_done <= (r_state == REPORT);
         if (r_state == IDLE && start) auth_pass <= 1'b0;
         else if (r_state == REPORT)   auth_pass <= r_result;
         if (r_state == REPORT) fail_count <= r_result ? 2'd0 : w_fail_inc;
      end
endmodule
